// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N_CH-to-1 valid/ready arbiter mux (round-robin or fixed priority) into one output register.
// Optional RR_ARB_MUX_PKT_LOCK_EN adds in_last/out_last and holds the grant until a packet ends.
module rr_arb_mux #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CHAN_W  = $clog2(N_CH),
  parameter int unsigned RR_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  input  logic [N_CH-1:0]          in_last,
  output logic                     out_last,
`endif
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CHAN_W-1:0]        out_chan,
  input  logic                     out_ready
);

  logic [CHAN_W-1:0] ptr_q, ptr_d;
  logic [CHAN_W-1:0] out_chan_q, out_chan_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [CHAN_W-1:0] gnt_idx;
  logic              gnt_found;
  logic [DATA_W-1:0] gnt_data;
  logic              load;
  logic              xfer;
  logic              pkt_end;
  int unsigned       scan;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  logic              lock_q, lock_d;
  logic              out_last_q, out_last_d;
`endif

  // Arbiter: first requester at/after the pointer (RR) or lowest index (fixed).
  always_comb begin : arb
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    for (int k = 0; k < int'(N_CH); k++) begin
      scan = (RR_MODE != 0) ? 32'(ptr_q) + 32'(k) : 32'(k);
      if (scan >= N_CH) scan = scan - N_CH;
      if (!gnt_found && in_valid[CHAN_W'(scan)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CHAN_W'(scan);
      end
    end
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    // Mid-packet the owner keeps the grant even while it idles.
    if (lock_q) begin
      gnt_idx   = out_chan_q;
      gnt_found = in_valid[out_chan_q];
    end
`endif
  end

  always_comb begin : data_sel
    gnt_data = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (CHAN_W'(k) == gnt_idx) gnt_data = in_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin : handshake
    load     = ~out_valid_q | out_ready;
    xfer     = gnt_found & load & rst_n;
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin : next_state
    pkt_end     = 1'b1;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    pkt_end     = in_last[gnt_idx];
    lock_d      = lock_q;
    out_last_d  = out_last_q;
`endif
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_chan_d  = gnt_idx;
      if (pkt_end) ptr_d = (gnt_idx == CHAN_W'(N_CH-1)) ? '0 : gnt_idx + CHAN_W'(1);
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      lock_d     = ~pkt_end;
      out_last_d = pkt_end;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: round-robin instance driven from a vector table with a word scoreboard,
// plus hand sequences for fixed priority, reset during stall and (if enabled) packet lock.
module tb_rr_arb_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic [3:0]  rdy_rr, rdy_fp;
  logic        ov_rr, ov_fp;
  logic [7:0]  od_rr, od_fp;
  logic [1:0]  oc_rr, oc_fp;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic        ol_rr, ol_fp;
`endif

  int total = 0;
  int bad   = 0;

  rr_arb_mux #(.DATA_W(8), .N_CH(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    .in_last(in_last), .out_last(ol_rr),
`endif
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_chan(oc_rr),
    .out_ready(out_ready)
  );

  rr_arb_mux #(.DATA_W(8), .N_CH(4), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    .in_last(in_last), .out_last(ol_fp),
`endif
    .in_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_chan(oc_fp),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
  } vec_t;

  typedef struct {
    logic [1:0] chan;
    logic [7:0] data;
  } word_t;

  vec_t  tbl [23];
  word_t sb [$];
  word_t held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2i(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

`ifdef RR_ARB_MUX_PKT_LOCK_EN
  task automatic lk(input logic [3:0] v, input logic [3:0] last, input logic [3:0] erdy,
                    input logic [1:0] echan, input logic elast);
    in_valid = v;
    in_last  = last;
    #1;
    chk("lock_in_ready", 32'(rdy_rr), 32'(erdy));
    tick;
    chk("lock_out_valid", 32'(ov_rr), 32'(erdy != 4'b0000));
    if (erdy != 4'b0000) begin
      chk("lock_out_chan", 32'(oc_rr), 32'(echan));
      chk("lock_out_last", 32'(ol_rr), 32'(elast));
    end
  endtask
`endif

  initial begin
    // Channel i carries 8'h10+i throughout.
    in_data   = 32'h1312_1110;
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    in_last   = 4'b1111;
`endif

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
    tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1};
    tbl[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1};
    tbl[12] = '{4'b1111, 1'b0, 4'b0000, 1'b1};
    tbl[13] = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[14] = '{4'b0100, 1'b1, 4'b0100, 1'b1};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[17] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[18] = '{4'b0000, 1'b0, 4'b0000, 1'b1};
    tbl[19] = '{4'b1111, 1'b1, 4'b0010, 1'b1};
    tbl[20] = '{4'b1001, 1'b1, 4'b1000, 1'b1};
    tbl[21] = '{4'b1001, 1'b1, 4'b0001, 1'b1};
    tbl[22] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

    tick;
    tick;
    chk("rst_out_valid", 32'(ov_rr), 32'(0));
    chk("rst_out_data", 32'(od_rr), 32'(0));
    chk("rst_out_chan", 32'(oc_rr), 32'(0));
    chk("rst_in_ready_rr", 32'(rdy_rr), 32'(0));
    chk("rst_in_ready_fp", 32'(rdy_fp), 32'(0));
    rst_n = 1'b1;

    held = '{2'd0, 8'h00};
    for (int i = 0; i < 23; i++) begin
      in_valid  = tbl[i].v;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("in_ready[%0d]", i), 32'(rdy_rr), 32'(tbl[i].exp_rdy));
      if (tbl[i].exp_rdy != 4'b0000)
        sb.push_back('{2'(oh2i(tbl[i].exp_rdy)), 8'(8'h10 + oh2i(tbl[i].exp_rdy))});
      tick;
      chk($sformatf("out_valid[%0d]", i), 32'(ov_rr), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_rdy != 4'b0000) begin
        if (sb.size() == 0) begin
          chk($sformatf("sb_empty[%0d]", i), 32'(1), 32'(0));
        end else begin
          held = sb.pop_front();
          chk($sformatf("out_chan[%0d]", i), 32'(oc_rr), 32'(held.chan));
          chk($sformatf("out_data[%0d]", i), 32'(od_rr), 32'(held.data));
        end
      end else if (tbl[i].exp_ov) begin
        chk($sformatf("hold_chan[%0d]", i), 32'(oc_rr), 32'(held.chan));
        chk($sformatf("hold_data[%0d]", i), 32'(od_rr), 32'(held.data));
      end
    end

    // Fixed priority: channel 1 beats 3 until it drops out.
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_in_ready_1", 32'(rdy_fp), 32'(4'b0010));
      tick;
      chk("fp_out_chan_1", 32'(oc_fp), 32'(1));
      chk("fp_out_data_1", 32'(od_fp), 32'(8'h11));
    end
    in_valid = 4'b1000;
    #1;
    chk("fp_in_ready_3", 32'(rdy_fp), 32'(4'b1000));
    tick;
    chk("fp_out_chan_3", 32'(oc_fp), 32'(3));
    chk("fp_out_data_3", 32'(od_fp), 32'(8'h13));
    chk("fp_out_valid", 32'(ov_fp), 32'(1));

    // Reset while a word is stalled: discarded immediately, pointer back to 0.
    in_valid = 4'b1111;
    tick;
    out_ready = 1'b0;
    tick;
    chk("stall_out_valid", 32'(ov_rr), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov_rr), 32'(0));
    chk("midrst_out_data", 32'(od_rr), 32'(0));
    chk("midrst_out_chan", 32'(oc_rr), 32'(0));
    chk("midrst_in_ready", 32'(rdy_rr), 32'(0));
    tick;
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(rdy_rr), 32'(4'b0001));

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    // Channel 2 owns the output for a 3-word packet, even across an idle cycle.
    out_ready = 1'b1;
    lk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    lk(4'b1101, 4'b0000, 4'b0100, 2'd2, 1'b0);
    lk(4'b1001, 4'b0000, 4'b0000, 2'd0, 1'b0);
    lk(4'b1101, 4'b0100, 4'b0100, 2'd2, 1'b1);
    lk(4'b1001, 4'b1001, 4'b1000, 2'd3, 1'b1);
    lk(4'b1001, 4'b1001, 4'b0001, 2'd0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
